// File: rtl/mem_io_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_arbiter_pkg
// Brief    : Shared FSM state encoding and parameter defaults for the
//            CPU/IO memory arbiter.
// Revision : 1.0
// ============================================================================
package mem_io_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_IO_ACC  = 2'd2
    } arb_state_t;

    localparam int unsigned C_WAIT_CYCLES_DEFAULT    = 1;
    localparam int unsigned C_MAX_CPU_STREAK_DEFAULT = 4;
    localparam int unsigned C_COUNT_W                = 4;
    localparam int unsigned C_DATA_W                 = 32;

endpackage
`default_nettype wire

// File: rtl/mem_io_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_arbiter_if
// Brief    : CPU, IO-master and memory buses of the arbiter; slave = arbiter
//            side, master = requesters plus memory.
// Revision : 1.0
// ============================================================================
interface mem_io_arbiter_if;
    import mem_io_arbiter_pkg::*;

    logic                cpu_req;
    logic                cpu_we;
    logic [C_DATA_W-1:0] cpu_addr;
    logic [C_DATA_W-1:0] cpu_wdata;
    logic                cpu_stall;
    logic [C_DATA_W-1:0] cpu_rdata;

    logic                io_req;
    logic                io_we;
    logic [C_DATA_W-1:0] io_addr;
    logic [C_DATA_W-1:0] io_wdata;
    logic                io_ack;
    logic [C_DATA_W-1:0] io_rdata;

    logic [C_DATA_W-1:0] mem_addr;
    logic [C_DATA_W-1:0] mem_wdata;
    logic                mem_we;
    logic [C_DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_ack, io_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_ack, io_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_io_arbiter_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_wait_counter
// Brief    : Loadable down-counter that stops at zero and flags it.
// Revision : 1.0
// ============================================================================
module arb_wait_counter
    import mem_io_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = C_COUNT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_arbiter
// Brief    : Arbitrates one memory port between the CPU MEM stage and an IO
//            master; MEM_IO_ARBITER_PERF_EN adds grant/stall counters.
// Revision : 1.0
// ============================================================================
module mem_io_arbiter
    import mem_io_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES    = C_WAIT_CYCLES_DEFAULT,
    parameter int unsigned MAX_CPU_STREAK = C_MAX_CPU_STREAK_DEFAULT
) (
    input  logic                clock,
    input  logic                resetn,
    mem_io_arbiter_if.slave     bus
`ifdef MEM_IO_ARBITER_PERF_EN
    ,
    output logic [C_DATA_W-1:0] cpu_grant_cnt,
    output logic [C_DATA_W-1:0] io_grant_cnt,
    output logic [C_DATA_W-1:0] stall_cnt
`endif
);

    localparam logic [C_COUNT_W-1:0] C_WAIT_LOAD  = C_COUNT_W'(WAIT_CYCLES);
    localparam logic [C_COUNT_W-1:0] C_MAX_STREAK = C_COUNT_W'(MAX_CPU_STREAK);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic [C_COUNT_W-1:0] r_streak;
    logic                 w_contested;
    logic                 w_cpu_grant;
    logic                 w_io_grant;
    logic                 w_load;
    logic                 w_zero;
    logic                 w_cpu_sel;
    logic                 w_io_sel;
    logic                 w_cpu_done;
    logic                 w_io_done;

    arb_wait_counter #(
        .WIDTH (C_COUNT_W)
    ) u_wait_counter (
        .clock      (clock),
        .resetn     (resetn),
        .load       (w_load),
        .load_value (C_WAIT_LOAD),
        .zero       (w_zero)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin : p_fsm
        w_state_next = r_state;
        w_cpu_grant  = 1'b0;
        w_io_grant   = 1'b0;
        w_contested  = bus.cpu_req && bus.io_req;

        case (r_state)
            ST_IDLE: begin
                if (w_contested) begin
                    if (r_streak == C_MAX_STREAK) w_io_grant  = 1'b1;
                    else                          w_cpu_grant = 1'b1;
                end else if (bus.cpu_req) begin
                    w_cpu_grant = 1'b1;
                end else if (bus.io_req) begin
                    w_io_grant = 1'b1;
                end
                if (w_cpu_grant)     w_state_next = ST_CPU_ACC;
                else if (w_io_grant) w_state_next = ST_IO_ACC;
            end
            ST_CPU_ACC, ST_IO_ACC: begin
                if (w_zero) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        w_load = w_cpu_grant || w_io_grant;

        // Outputs are gated by resetn so an access caught by reset never completes.
        w_cpu_sel  = resetn && (r_state == ST_CPU_ACC);
        w_io_sel   = resetn && (r_state == ST_IO_ACC);
        w_cpu_done = w_cpu_sel && w_zero;
        w_io_done  = w_io_sel && w_zero;

        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_rdata = '0;
        bus.io_rdata  = '0;
        bus.io_ack    = w_io_done;
        bus.cpu_stall = bus.cpu_req && !w_cpu_done;

        if (w_cpu_sel) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = w_cpu_done && bus.cpu_we;
        end else if (w_io_sel) begin
            bus.mem_addr  = bus.io_addr;
            bus.mem_wdata = bus.io_wdata;
            bus.mem_we    = w_io_done && bus.io_we;
        end

        if (w_cpu_done) bus.cpu_rdata = bus.mem_rdata;
        if (w_io_done)  bus.io_rdata  = bus.mem_rdata;
    end

    // Only contested CPU wins build the streak; it never passes the limit
    // because reaching it hands the next contest to IO.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_streak <= '0;
        end else if (w_io_grant) begin
            r_streak <= '0;
        end else if (w_cpu_grant && w_contested && (r_streak != C_MAX_STREAK)) begin
            r_streak <= r_streak + C_COUNT_W'(1);
        end
    end

`ifdef MEM_IO_ARBITER_PERF_EN
    logic [C_DATA_W-1:0] r_cpu_grant_cnt;
    logic [C_DATA_W-1:0] r_io_grant_cnt;
    logic [C_DATA_W-1:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_cpu_grant_cnt <= '0;
            r_io_grant_cnt  <= '0;
            r_stall_cnt     <= '0;
        end else begin
            if (w_cpu_grant)   r_cpu_grant_cnt <= r_cpu_grant_cnt + C_DATA_W'(1);
            if (w_io_grant)    r_io_grant_cnt  <= r_io_grant_cnt + C_DATA_W'(1);
            if (bus.cpu_stall) r_stall_cnt     <= r_stall_cnt + C_DATA_W'(1);
        end
    end

    assign cpu_grant_cnt = r_cpu_grant_cnt;
    assign io_grant_cnt  = r_io_grant_cnt;
    assign stall_cnt     = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_arbiter
// Brief    : Randomised, model-checked bench for mem_io_arbiter (WAIT=1, MAX=4)
//            plus directed WAIT=0 instance; honours MEM_IO_ARBITER_PERF_EN.
// Revision : 1.0
// ============================================================================
module tb_mem_io_arbiter;

    localparam int WAIT  = 1;
    localparam int MAXS  = 4;
    localparam int MAXS0 = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    mem_io_arbiter_if bus ();
    mem_io_arbiter_if bus0 ();

    logic [31:0] mem  [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] mem0 [0:255];

    int checks = 0;
    int errors = 0;

`ifdef MEM_IO_ARBITER_PERF_EN
    logic [31:0] cpu_grant_cnt, io_grant_cnt, stall_cnt;
    logic [31:0] cpu_grant_cnt0, io_grant_cnt0, stall_cnt0;
`endif

    mem_io_arbiter #(.WAIT_CYCLES(WAIT), .MAX_CPU_STREAK(MAXS)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
`ifdef MEM_IO_ARBITER_PERF_EN
        , .cpu_grant_cnt (cpu_grant_cnt)
        , .io_grant_cnt  (io_grant_cnt)
        , .stall_cnt     (stall_cnt)
`endif
    );

    mem_io_arbiter #(.WAIT_CYCLES(0), .MAX_CPU_STREAK(MAXS0)) dut0 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus0)
`ifdef MEM_IO_ARBITER_PERF_EN
        , .cpu_grant_cnt (cpu_grant_cnt0)
        , .io_grant_cnt  (io_grant_cnt0)
        , .stall_cnt     (stall_cnt0)
`endif
    );

    assign bus.mem_rdata  = mem[bus.mem_addr[9:2]];
    assign bus0.mem_rdata = mem0[bus0.mem_addr[9:2]];

    always @(posedge clock) begin
        if (bus.mem_we)  mem[bus.mem_addr[9:2]]   = bus.mem_wdata;
        if (bus0.mem_we) mem0[bus0.mem_addr[9:2]] = bus0.mem_wdata;
    end

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Transaction-level reference: who owns the memory, cycles left, streak.
    int          own    = 0;
    int          rem    = 0;
    int          streak = 0;
    logic [31:0] pcpu   = 0;
    logic [31:0] pio    = 0;
    logic [31:0] pstall = 0;
    bit          perf_sync = 1'b0;

    always @(negedge clock) begin : p_model
        logic [31:0] e_addr, e_wdata, e_crd, e_ird;
        logic        e_we, e_ack, e_stall;
        bit          done;
        e_addr = 0; e_wdata = 0; e_crd = 0; e_ird = 0;
        e_we = 0; e_ack = 0; done = 0;
        if (resetn && own != 0) begin
            done = (rem == 0);
            if (own == 1) begin
                e_addr  = bus.cpu_addr;
                e_wdata = bus.cpu_wdata;
                if (done) begin
                    e_we  = bus.cpu_we;
                    e_crd = ref_mem[idx(bus.cpu_addr)];
                end
            end else begin
                e_addr  = bus.io_addr;
                e_wdata = bus.io_wdata;
                if (done) begin
                    e_we  = bus.io_we;
                    e_ack = 1'b1;
                    e_ird = ref_mem[idx(bus.io_addr)];
                end
            end
        end
        e_stall = bus.cpu_req && !(own == 1 && done && resetn);

        chk("model_cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        chk("model_cpu_rdata", bus.cpu_rdata, e_crd);
        chk("model_io_ack",    32'(bus.io_ack), 32'(e_ack));
        chk("model_io_rdata",  bus.io_rdata, e_ird);
        chk("model_mem_addr",  bus.mem_addr, e_addr);
        chk("model_mem_wdata", bus.mem_wdata, e_wdata);
        chk("model_mem_we",    32'(bus.mem_we), 32'(e_we));
`ifdef MEM_IO_ARBITER_PERF_EN
        if (perf_sync) begin
            chk("model_cpu_grant_cnt", cpu_grant_cnt, pcpu);
            chk("model_io_grant_cnt",  io_grant_cnt, pio);
            chk("model_stall_cnt",     stall_cnt, pstall);
        end
`endif

        if (!resetn) begin
            own = 0; rem = 0; streak = 0;
            pcpu = 0; pio = 0; pstall = 0;
            perf_sync = 1'b1;
        end else begin
            if (e_stall) pstall++;
            if (e_we) ref_mem[idx(e_addr)] = e_wdata;
            if (own != 0) begin
                if (done) own = 0;
                else      rem--;
            end else if (bus.cpu_req && bus.io_req) begin
                if (streak == MAXS) begin own = 2; streak = 0; pio++; end
                else                begin own = 1; streak++;   pcpu++; end
                rem = WAIT;
            end else if (bus.cpu_req) begin
                own = 1; rem = WAIT; pcpu++;
            end else if (bus.io_req) begin
                own = 2; rem = WAIT; streak = 0; pio++;
            end
        end
    end

    initial begin : p_watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_stim
        logic [31:0] orig;
        int          seq[$];
        bit          cdone, idone;
`ifdef MEM_IO_ARBITER_PERF_EN
        int          seen_stall;
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
            mem0[i]    = 32'h0;
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;

        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_wdata = 0;
        bus.io_req = 1'b0; bus.io_we = 1'b0; bus.io_addr = 0; bus.io_wdata = 0;
        bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
        bus0.io_req = 1'b0; bus0.io_we = 1'b0; bus0.io_addr = 0; bus0.io_wdata = 0;

        // Reset: stall follows cpu_req, everything else quiet.
        @(negedge clock);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'h1);
        chk("rst_mem_we",    32'(bus.mem_we), 32'h0);
        chk("rst_io_ack",    32'(bus.io_ack), 32'h0);
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        tick(); bus.cpu_req = 1'b0;
        tick(); resetn = 1'b1;

        // CPU load from 0x10, WAIT=1.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            chk("load_stall",  32'(bus.cpu_stall), 32'(c < 3));
            chk("load_rdata",  bus.cpu_rdata, (c == 3) ? 32'hDEADBEEF : 32'h0);
            chk("load_mem_we", 32'(bus.mem_we), 32'h0);
            if (c < 3) tick();
        end
        tick(); bus.cpu_req = 1'b0;

        // IO write 0x12345678 to 0x20.
        bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 32'h20; bus.io_wdata = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            chk("iowr_ack",    32'(bus.io_ack), 32'(c == 3));
            chk("iowr_mem_we", 32'(bus.mem_we), 32'(c == 3));
            if (c < 3) tick();
        end
        tick(); bus.io_req = 1'b0; bus.io_we = 1'b0;
        @(negedge clock);
        chk("iowr_mem_content", mem[8], 32'h12345678);

        // Reset while a CPU store waits with counter=1: store must vanish.
        tick();
        orig = mem[12];
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'hBAD0BAD0;
        @(negedge clock);
        chk("abort_c1_stall", 32'(bus.cpu_stall), 32'h1);
        tick(); resetn = 1'b0;
        @(negedge clock);
        chk("abort_c2_mem_we", 32'(bus.mem_we), 32'h0);
        chk("abort_c2_io_ack", 32'(bus.io_ack), 32'h0);
        tick(); resetn = 1'b1; bus.cpu_we = 1'b0;
        @(negedge clock);
        chk("abort_c3_idle_addr", bus.mem_addr, 32'h0);
        chk("abort_c3_mem_we",    32'(bus.mem_we), 32'h0);
        tick();
        @(negedge clock);
        chk("abort_c4_stall", 32'(bus.cpu_stall), 32'h1);
        tick();
        @(negedge clock);
        chk("abort_c5_stall", 32'(bus.cpu_stall), 32'h0);
        chk("abort_c5_rdata", bus.cpu_rdata, orig);
        tick(); bus.cpu_req = 1'b0;

        // Both held: CPU x4 then IO, repeating.
        tick();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h14;
        bus.io_req = 1'b1; bus.io_we = 1'b0; bus.io_addr = 32'h18;
        seq.delete();
        for (int cyc = 0; cyc < 60 && seq.size() < 10; cyc++) begin
            @(negedge clock);
            if (!bus.cpu_stall) seq.push_back(1);
            if (bus.io_ack)     seq.push_back(2);
            tick();
        end
        chk("fair_count", 32'(seq.size()), 32'd10);
        for (int k = 0; k < seq.size(); k++)
            chk("fair_order", 32'(seq[k]), (k % 5 == 4) ? 32'd2 : 32'd1);
        bus.cpu_req = 1'b0; bus.io_req = 1'b0;
        repeat (4) tick();

        // WAIT=0 instance: store completes in the first access cycle.
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 32'h4; bus0.cpu_wdata = 32'hCAFEF00D;
        @(negedge clock);
        chk("w0_c1_stall",  32'(bus0.cpu_stall), 32'h1);
        chk("w0_c1_mem_we", 32'(bus0.mem_we), 32'h0);
        tick();
        @(negedge clock);
        chk("w0_c2_stall",     32'(bus0.cpu_stall), 32'h0);
        chk("w0_c2_mem_we",    32'(bus0.mem_we), 32'h1);
        chk("w0_c2_mem_addr",  bus0.mem_addr, 32'h4);
        chk("w0_c2_mem_wdata", bus0.mem_wdata, 32'hCAFEF00D);
        tick(); bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0;
        @(negedge clock);
        chk("w0_mem_content", mem0[1], 32'hCAFEF00D);

        // WAIT=0, MAX=2 contention: CPU, CPU, IO repeating.
        tick();
        bus0.cpu_req = 1'b1; bus0.io_req = 1'b1;
        seq.delete();
        for (int cyc = 0; cyc < 40 && seq.size() < 6; cyc++) begin
            @(negedge clock);
            if (!bus0.cpu_stall) seq.push_back(1);
            if (bus0.io_ack)     seq.push_back(2);
            tick();
        end
        chk("w0_fair_count", 32'(seq.size()), 32'd6);
        for (int k = 0; k < seq.size(); k++)
            chk("w0_fair_order", 32'(seq[k]), (k % 3 == 2) ? 32'd2 : 32'd1);
        bus0.cpu_req = 1'b0; bus0.io_req = 1'b0;
        repeat (3) tick();

`ifdef MEM_IO_ARBITER_PERF_EN
        // 3 CPU and 2 IO accesses from a fresh reset.
        resetn = 1'b0; tick(); resetn = 1'b1;
        seen_stall = 0;
        for (int a = 0; a < 5; a++) begin
            bit is_cpu;
            bit got;
            is_cpu = (a != 1 && a != 3);
            got = 1'b0;
            if (is_cpu) begin bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'(a * 4); end
            else        begin bus.io_req = 1'b1; bus.io_we = 1'b0; bus.io_addr = 32'(a * 4); end
            for (int cyc = 0; cyc < 10 && !got; cyc++) begin
                @(negedge clock);
                if (bus.cpu_stall) seen_stall++;
                got = is_cpu ? !bus.cpu_stall : bus.io_ack;
                tick();
            end
            chk("perf_access_done", 32'(got), 32'h1);
            bus.cpu_req = 1'b0; bus.io_req = 1'b0;
        end
        @(negedge clock);
        chk("perf_cpu_grant_cnt", cpu_grant_cnt, 32'd3);
        chk("perf_io_grant_cnt",  io_grant_cnt, 32'd2);
        chk("perf_stall_cnt",     stall_cnt, 32'(seen_stall));
        chk("perf_stall_seen",    32'(seen_stall), 32'd6);
        tick();
`endif

        // Randomised traffic with retractions and occasional resets.
        for (int n = 0; n < 2500; n++) begin
            @(negedge clock);
            cdone = bus.cpu_req && !bus.cpu_stall;
            idone = bus.io_ack;
            tick();
            if (!bus.cpu_req || cdone) begin
                if ($urandom_range(0, 99) < 55) begin
                    bus.cpu_req   = 1'b1;
                    bus.cpu_we    = 1'($urandom_range(0, 1));
                    bus.cpu_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    bus.cpu_wdata = $urandom;
                end else begin
                    bus.cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 2) begin
                bus.cpu_req = 1'b0;
            end
            if (!bus.io_req || idone) begin
                if ($urandom_range(0, 99) < 45) begin
                    bus.io_req   = 1'b1;
                    bus.io_we    = 1'($urandom_range(0, 1));
                    bus.io_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    bus.io_wdata = $urandom;
                end else begin
                    bus.io_req = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 2) begin
                bus.io_req = 1'b0;
            end
            resetn = ($urandom_range(0, 399) != 0);
        end

        tick();
        bus.cpu_req = 1'b0; bus.io_req = 1'b0; resetn = 1'b1;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
